session_ctrl_p: RTL and testbench
=================================

// Module: session_ctrl_p
// PURPOSE
//  Parametrised call-session controller sitting between the user keypad decoder and the transport layer.
//  Dials, rings, answers, rejects, holds/resumes and hangs up calls, then streams audio both ways while connected.
//  Sends a BUSY reply when a second call arrives. Dial and ring attempts time out.
//  Control word format: {peer_addr[ADDR_W-1:0], opcode[7:0]} in the low ADDR_W+8 bits; upper bits are zero.
// PARAMETERS
//  ADDR_W       8     phone-number width
//  DATA_W       16    transport word width; must be >= ADDR_W+8
//  TIMEOUT_CYC  1000  cycles CALLING/RINGING may last before timeout (>=2)
//  VM_CYC       4000  voicemail record window in cycles (used only with VOICEMAIL_EN)
// PORTS
//  clk              in   1       system clock
//  reset_n          in   1       asynchronous, active-low reset
//  phone_num        in   ADDR_W  number to dial, sampled on user_inp==DIAL
//  user_inp         in   5       1=DIAL 2=ANSWER 3=REJECT 4=HOLD/RESUME toggle 5=HANGUP 0=none
//  audio_in         in   DATA_W  local audio sample
//  cmd_in           in   2       00 none, 01 control, 10 audio; qualifies packet_in for one cycle
//  packet_in        in   DATA_W  incoming transport word
//  transport_busy   in   1       transport cannot accept a word this cycle
//  cmd_out          out  2       00 none, 01 control, 10 audio
//  data_out         out  DATA_W  outgoing word, valid while cmd_out!=0
//  audio_in_flag    out  1       audio_in consumed this cycle
//  audio_out_valid  out  1       audio_out holds a new far-end sample
//  audio_out        out  DATA_W  far-end audio sample
//  session_busy     out  1       high in RINGING (user must respond)
//  peer_num         out  ADDR_W  current peer number
//  call_status      out  2       last end cause: 0 none, 1 peer busy, 2 no answer, 3 rejected/hung up
//  vm_active        out  1       voicemail recording in progress (0 when macro is off)
//  current_state    out  3       FSM state code
// BEHAVIOUR
//  - Opcodes: 01 CALL, 02 ANSWER, 03 BUSY, 04 HOLD, 05 HANGUP, 06 RESUME, 07 REJECT.
//  - All outputs are registered. On reset: outputs 0, state IDLE, timer cleared, pending word dropped.
//    Reset has immediate effect mid-call; no HANGUP is sent.
//  - TX rule: a word with cmd_out!=0 is accepted at the first rising edge where transport_busy==0.
//    While the word is unaccepted, cmd_out and data_out stay stable.
//    Control words take priority over audio. Only one control word is pending at a time.
//    A newer control request overwrites an unsent one.
//  - States (current_state): IDLE=0, CALLING=1, RINGING=2, CONNECTED=3, HELD=4, NO_ANSWER=5, VOICEMAIL=6.
//  - IDLE, DIAL: send {phone_num,CALL}, latch peer, load timer, go to CALLING.
//    If DIAL and an incoming CALL arrive in the same cycle, the incoming CALL wins: RINGING, no CALL sent.
//  - IDLE, incoming CALL: latch peer, load timer, go to RINGING.
//  - CALLING: ANSWER from the peer goes to CONNECTED. BUSY or REJECT from the peer goes to IDLE with status 1 or 3.
//    HANGUP from the user sends HANGUP and goes to IDLE. Timer reaching 0 goes to NO_ANSWER, which sends HANGUP.
//    NO_ANSWER lasts 1 cycle, sets status 2, then goes to IDLE.
//  - RINGING: ANSWER sends ANSWER and goes to CONNECTED. REJECT sends REJECT and goes to IDLE.
//    Timer reaching 0 goes to IDLE (or VOICEMAIL, see below). A peer HANGUP goes to IDLE with status 3.
//  - CONNECTED: each cycle with no pending control word and transport_busy==0 emits cmd_out=10, data_out=audio_in.
//    audio_in_flag=1 in that same cycle.
//    Incoming audio sets audio_out_valid=1 for 1 cycle with audio_out=packet_in.
//    HOLD toggle sends HOLD and goes to HELD. A peer HOLD also goes to HELD.
//  - HELD: no audio in either direction; incoming audio is dropped.
//    The toggle sends RESUME and goes to CONNECTED. A peer RESUME also goes to CONNECTED.
//  - CONNECTED/HELD: user HANGUP sends HANGUP and goes to IDLE with status 3. A peer HANGUP goes to IDLE with status 3.
//    If a user HANGUP and a peer HANGUP occur in the same cycle, the peer wins: no HANGUP is sent.
//  - Peer filter: control words whose address is not peer_num are ignored outside IDLE.
//    Exception: a CALL from any other address is answered with {addr,BUSY}; the state does not change.
//  - Timer: a TO_W=$clog2(TIMEOUT_CYC+1) bit down-counter. It loads TIMEOUT_CYC on entering CALLING or RINGING.
//    It decrements each cycle and saturates at 0. It is not reloaded by non-peer traffic.
//  - user_inp codes that are invalid for the current state are ignored. call_status clears on the next DIAL or CALL.
// CONFIGURATION
//  - VOICEMAIL_EN defined:
//    * RINGING timeout sends {peer,ANSWER} and goes to VOICEMAIL, with vm_active=1.
//    * Incoming audio appears on audio_out/audio_out_valid.
//    * No local audio is sent.
//    * Leaves after VM_CYC cycles (sends HANGUP) or on a peer HANGUP.
//    * Then goes to IDLE with vm_active=0.
//  - VOICEMAIL_EN undefined: the VOICEMAIL state, its counter and VM_CYC logic are absent.
//    vm_active is tied to 0. A RINGING timeout goes to IDLE.
// TESTING
//  1. DIAL with phone_num=0x2A -> cmd_out=01, data_out=0x2A01. Peer ANSWER 0x2A02 -> state 3.
//     Then audio_in=0x1234 with busy=0 -> cmd_out=10, data_out=0x1234, audio_in_flag=1.
//  2. Incoming 0x0701 -> state 2, session_busy=1, peer_num=0x07. ANSWER -> data_out=0x0702, state 3.
//     Peer 0x0705 -> state 0, status 3.
//  3. CALLING with TIMEOUT_CYC=8 and no reply -> NO_ANSWER exactly 8 cycles after CALL accepted.
//     Then data_out=0x2A05, status 2, IDLE.
//  4. CONNECTED with peer 0x2A, transport_busy=1 for 5 cycles, user HANGUP -> data_out=0x2A05 held stable.
//     Word accepted on the first busy=0 edge. No audio emitted meanwhile.
//  5. CONNECTED with peer 0x2A, incoming 0x3301 -> data_out=0x3303 sent, state stays 3.
//     Then HOLD toggle -> 0x2A04, state 4, and incoming audio gives audio_out_valid=0.
//  6. Assert reset_n=0 mid-CONNECTED, with and without VOICEMAIL_EN -> outputs 0 immediately, state 0.
//     With VOICEMAIL_EN, a RINGING timeout -> 0x..02 sent, vm_active=1 for VM_CYC cycles.

Source files
------------

// File: rtl/session_ctrl_p.sv
// Call-session controller between keypad decoder and transport layer.
// Optional voicemail answering is enabled with `define VOICEMAIL_EN.
module session_ctrl_p #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1000,
  parameter int VM_CYC      = 4000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] phone_num,
  input  logic [4:0]        user_inp,
  input  logic [DATA_W-1:0] audio_in,
  input  logic [1:0]        cmd_in,
  input  logic [DATA_W-1:0] packet_in,
  input  logic              transport_busy,
  output logic [1:0]        cmd_out,
  output logic [DATA_W-1:0] data_out,
  output logic              audio_in_flag,
  output logic              audio_out_valid,
  output logic [DATA_W-1:0] audio_out,
  output logic              session_busy,
  output logic [ADDR_W-1:0] peer_num,
  output logic [1:0]        call_status,
  output logic              vm_active,
  output logic [2:0]        current_state
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

  if (DATA_W < ADDR_W + 8) begin : g_chk_w
    $error("DATA_W too narrow for control words");
  end
  if (TIMEOUT_CYC < 2 || VM_CYC < 1) begin : g_chk_t
    $error("timeout parameters out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALLING = 3'd1,
    S_RINGING = 3'd2,
    S_CONN    = 3'd3,
    S_HELD    = 3'd4,
    S_NOANS   = 3'd5,
    S_VM      = 3'd6
  } state_t;

  localparam logic [7:0] OP_CALL   = 8'h01;
  localparam logic [7:0] OP_ANSWER = 8'h02;
  localparam logic [7:0] OP_BUSY   = 8'h03;
  localparam logic [7:0] OP_HOLD   = 8'h04;
  localparam logic [7:0] OP_HANGUP = 8'h05;
  localparam logic [7:0] OP_RESUME = 8'h06;
  localparam logic [7:0] OP_REJECT = 8'h07;

  localparam logic [4:0] U_DIAL   = 5'd1;
  localparam logic [4:0] U_ANSWER = 5'd2;
  localparam logic [4:0] U_REJECT = 5'd3;
  localparam logic [4:0] U_HOLD   = 5'd4;
  localparam logic [4:0] U_HANGUP = 5'd5;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_CTL  = 2'b01;
  localparam logic [1:0] C_AUD  = 2'b10;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [ADDR_W-1:0] peer_q, peer_d;
  logic [1:0]        status_q, status_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] pword_q, pword_d;
  logic              flag_q, flag_d;
  logic              aov_q, aov_d;
  logic [DATA_W-1:0] aout_q, aout_d;
  logic              sbusy_q;
  logic              vm_q;

  logic              req, to_load;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_op;
  logic [DATA_W-1:0] req_word, ctl_src;
  logic              have_ctl, accept, aud_ok;

`ifdef VOICEMAIL_EN
  localparam int VM_W = $clog2(VM_CYC + 1);
  localparam logic [VM_W-1:0] VM_MAX = VM_W'(VM_CYC);
  logic [VM_W-1:0] vmcnt_q, vmcnt_d;
  logic            vm_load;
`endif

  // Control words carry zeros above {addr, opcode}; anything else is noise.
  wire              hi_zero = (packet_in >> (ADDR_W + 8)) == '0;
  wire              rx_ctl  = (cmd_in == C_CTL) && hi_zero;
  wire              rx_aud  = (cmd_in == C_AUD);
  wire [ADDR_W-1:0] rx_addr = packet_in[ADDR_W+7:8];
  wire [7:0]        rx_op   = packet_in[7:0];
  wire              peer_hit = rx_ctl && (rx_addr == peer_q);

  always_comb begin
    state_d  = state_q;
    peer_d   = peer_q;
    status_d = status_q;
    req      = 1'b0;
    req_addr = peer_q;
    req_op   = OP_HANGUP;
    to_load  = 1'b0;
`ifdef VOICEMAIL_EN
    vm_load  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_ctl && rx_op == OP_CALL) begin
          peer_d   = rx_addr;
          status_d = 2'd0;
          to_load  = 1'b1;
          state_d  = S_RINGING;
        end else if (user_inp == U_DIAL) begin
          req      = 1'b1;
          req_addr = phone_num;
          req_op   = OP_CALL;
          peer_d   = phone_num;
          status_d = 2'd0;
          to_load  = 1'b1;
          state_d  = S_CALLING;
        end
      end
      S_CALLING: begin
        if (peer_hit && rx_op == OP_ANSWER) begin
          state_d = S_CONN;
        end else if (peer_hit && rx_op == OP_BUSY) begin
          state_d  = S_IDLE;
          status_d = 2'd1;
        end else if (peer_hit && rx_op == OP_REJECT) begin
          state_d  = S_IDLE;
          status_d = 2'd3;
        end else if (user_inp == U_HANGUP) begin
          req      = 1'b1;
          state_d  = S_IDLE;
          status_d = 2'd3;
        end else if (timer_q == '0) begin
          req      = 1'b1;
          state_d  = S_NOANS;
          status_d = 2'd2;
        end
      end
      S_RINGING: begin
        if (peer_hit && rx_op == OP_HANGUP) begin
          state_d  = S_IDLE;
          status_d = 2'd3;
        end else if (user_inp == U_ANSWER) begin
          req     = 1'b1;
          req_op  = OP_ANSWER;
          state_d = S_CONN;
        end else if (user_inp == U_REJECT) begin
          req      = 1'b1;
          req_op   = OP_REJECT;
          state_d  = S_IDLE;
          status_d = 2'd3;
        end else if (timer_q == '0) begin
`ifdef VOICEMAIL_EN
          req     = 1'b1;
          req_op  = OP_ANSWER;
          vm_load = 1'b1;
          state_d = S_VM;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_NOANS: state_d = S_IDLE;
      S_CONN, S_HELD: begin
        if (peer_hit && rx_op == OP_HANGUP) begin
          state_d  = S_IDLE;
          status_d = 2'd3;
        end else if (user_inp == U_HANGUP) begin
          req      = 1'b1;
          state_d  = S_IDLE;
          status_d = 2'd3;
        end else if (user_inp == U_HOLD) begin
          req     = 1'b1;
          req_op  = (state_q == S_CONN) ? OP_HOLD : OP_RESUME;
          state_d = (state_q == S_CONN) ? S_HELD : S_CONN;
        end else if (peer_hit && rx_op == OP_HOLD && state_q == S_CONN) begin
          state_d = S_HELD;
        end else if (peer_hit && rx_op == OP_RESUME && state_q == S_HELD) begin
          state_d = S_CONN;
        end
      end
`ifdef VOICEMAIL_EN
      S_VM: begin
        if (peer_hit && rx_op == OP_HANGUP) begin
          state_d  = S_IDLE;
          status_d = 2'd3;
        end else if (vmcnt_q <= VM_W'(1)) begin
          req     = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // A third party calling in gets BUSY unless a session request owns the slot.
    if (state_q != S_IDLE && rx_ctl && rx_addr != peer_q &&
        rx_op == OP_CALL && !req) begin
      req      = 1'b1;
      req_addr = rx_addr;
      req_op   = OP_BUSY;
    end
  end

  always_comb begin
    timer_d = to_load ? TO_MAX :
              (timer_q != '0) ? timer_q - TO_W'(1) : '0;
`ifdef VOICEMAIL_EN
    vmcnt_d = vm_load ? VM_MAX :
              (vmcnt_q != '0) ? vmcnt_q - VM_W'(1) : '0;
`endif
  end

  assign req_word = DATA_W'({req_addr, req_op});
  assign have_ctl = req || pend_q;
  assign ctl_src  = req ? req_word : pword_q;
  assign accept   = (cmd_q != C_NONE) && !transport_busy;
  assign aud_ok   = (state_q == S_CONN) && (state_d == S_CONN) &&
                    !transport_busy;

  // A stalled audio sample is stale once a control word is waiting.
  always_comb begin
    cmd_d   = cmd_q;
    data_d  = data_q;
    pend_d  = pend_q;
    pword_d = pword_q;
    flag_d  = 1'b0;
    if (have_ctl && (cmd_q != C_CTL || accept)) begin
      cmd_d  = C_CTL;
      data_d = ctl_src;
      pend_d = 1'b0;
    end else if (have_ctl) begin
      pend_d  = 1'b1;
      pword_d = ctl_src;
    end else if (cmd_q == C_NONE || accept) begin
      if (aud_ok) begin
        cmd_d  = C_AUD;
        data_d = audio_in;
        flag_d = 1'b1;
      end else begin
        cmd_d = C_NONE;
      end
    end
  end

  always_comb begin
`ifdef VOICEMAIL_EN
    aov_d = rx_aud && (state_q == S_CONN || state_q == S_VM);
`else
    aov_d = rx_aud && (state_q == S_CONN);
`endif
    aout_d = aov_d ? packet_in : aout_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      peer_q   <= '0;
      status_q <= 2'd0;
      cmd_q    <= C_NONE;
      data_q   <= '0;
      pend_q   <= 1'b0;
      pword_q  <= '0;
      flag_q   <= 1'b0;
      aov_q    <= 1'b0;
      aout_q   <= '0;
      sbusy_q  <= 1'b0;
      vm_q     <= 1'b0;
`ifdef VOICEMAIL_EN
      vmcnt_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      peer_q   <= peer_d;
      status_q <= status_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      pword_q  <= pword_d;
      flag_q   <= flag_d;
      aov_q    <= aov_d;
      aout_q   <= aout_d;
      sbusy_q  <= (state_d == S_RINGING);
      vm_q     <= (state_d == S_VM);
`ifdef VOICEMAIL_EN
      vmcnt_q  <= vmcnt_d;
`endif
    end
  end

  assign cmd_out         = cmd_q;
  assign data_out        = data_q;
  assign audio_in_flag   = flag_q;
  assign audio_out_valid = aov_q;
  assign audio_out       = aout_q;
  assign session_busy    = sbusy_q;
  assign peer_num        = peer_q;
  assign call_status     = status_q;
  assign vm_active       = vm_q;
  assign current_state   = state_q;

endmodule

// File: tb/tb_session_ctrl_p.sv
// Directed-vector bench for session_ctrl_p (TIMEOUT_CYC=8, VM_CYC=6).
// Voicemail checks are built when VOICEMAIL_EN is defined.
module tb_session_ctrl_p;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  phone_num;
  logic [4:0]  user_inp;
  logic [15:0] audio_in;
  logic [1:0]  cmd_in;
  logic [15:0] packet_in;
  logic        transport_busy;
  logic [1:0]  cmd_out;
  logic [15:0] data_out;
  logic        audio_in_flag;
  logic        audio_out_valid;
  logic [15:0] audio_out;
  logic        session_busy;
  logic [7:0]  peer_num;
  logic [1:0]  call_status;
  logic        vm_active;
  logic [2:0]  current_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  session_ctrl_p #(
    .ADDR_W(8), .DATA_W(16), .TIMEOUT_CYC(8), .VM_CYC(6)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .phone_num(phone_num), .user_inp(user_inp),
    .audio_in(audio_in), .cmd_in(cmd_in),
    .packet_in(packet_in), .transport_busy(transport_busy),
    .cmd_out(cmd_out), .data_out(data_out),
    .audio_in_flag(audio_in_flag),
    .audio_out_valid(audio_out_valid),
    .audio_out(audio_out), .session_busy(session_busy),
    .peer_num(peer_num), .call_status(call_status),
    .vm_active(vm_active), .current_state(current_state)
  );

  typedef struct {
    logic [4:0]  ui;
    logic [7:0]  ph;
    logic [1:0]  ci;
    logic [15:0] pk;
    logic        bz;
    logic [15:0] ai;
    logic [2:0]  st;
    logic [1:0]  co;
    logic [15:0] dout;
    logic        fl;
    logic [1:0]  cs;
    logic [7:0]  pn;
    logic        sb;
    logic        av;
    logic [15:0] ao;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic [4:0] ui, logic [7:0] ph, logic [1:0] ci,
    logic [15:0] pk, logic bz, logic [15:0] ai,
    logic [2:0] st, logic [1:0] co, logic [15:0] dout,
    logic fl, logic [1:0] cs, logic [7:0] pn,
    logic sb, logic av, logic [15:0] ao);
    vec_t v;
    v.ui = ui; v.ph = ph; v.ci = ci; v.pk = pk;
    v.bz = bz; v.ai = ai; v.st = st; v.co = co;
    v.dout = dout; v.fl = fl; v.cs = cs; v.pn = pn;
    v.sb = sb; v.av = av; v.ao = ao;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [4:0] ui, logic [7:0] ph, logic [1:0] ci,
                       logic [15:0] pk, logic bz, logic [15:0] ai);
    user_inp = ui; phone_num = ph; cmd_in = ci;
    packet_in = pk; transport_busy = bz; audio_in = ai;
  endtask

  task automatic idle();
    drive(5'd0, 8'h00, 2'b00, 16'h0000, 1'b0, 16'h0000);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, " cmd"}, 32'(cmd_out), 0);
    chk({nm, " data"}, 32'(data_out), 0);
    chk({nm, " flag"}, 32'(audio_in_flag), 0);
    chk({nm, " aov"}, 32'(audio_out_valid), 0);
    chk({nm, " aout"}, 32'(audio_out), 0);
    chk({nm, " sbusy"}, 32'(session_busy), 0);
    chk({nm, " peer"}, 32'(peer_num), 0);
    chk({nm, " status"}, 32'(call_status), 0);
    chk({nm, " vm"}, 32'(vm_active), 0);
    chk({nm, " state"}, 32'(current_state), 0);
  endtask

  initial begin
    int cnt;
    reset_n = 1'b0;
    idle();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // DIAL/answer/audio, BUSY to a third party, hold/resume
    vt.push_back(mk(1, 8'h2A, 0, 16'h0000, 0, 16'h0000,
                    1, 1, 16'h2A01, 0, 0, 8'h2A, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 16'h2A02, 0, 16'h0000,
                    3, 0, 0, 0, 0, 8'h2A, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h1234,
                    3, 2, 16'h1234, 1, 0, 8'h2A, 0, 0, 0));
    vt.push_back(mk(0, 0, 2, 16'hBEEF, 0, 16'h5678,
                    3, 2, 16'h5678, 1, 0, 8'h2A, 0, 1, 16'hBEEF));
    vt.push_back(mk(0, 0, 1, 16'h3301, 0, 16'h1111,
                    3, 1, 16'h3303, 0, 0, 8'h2A, 0, 0, 0));
    vt.push_back(mk(4, 0, 0, 16'h0000, 0, 16'h2222,
                    4, 1, 16'h2A04, 0, 0, 8'h2A, 0, 0, 0));
    vt.push_back(mk(0, 0, 2, 16'h4444, 0, 16'h0000,
                    4, 0, 0, 0, 0, 8'h2A, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 16'h2A06, 0, 16'h0000,
                    3, 0, 0, 0, 0, 8'h2A, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h3333,
                    3, 2, 16'h3333, 1, 0, 8'h2A, 0, 0, 0));
    // HANGUP stalled by a busy transport for 5 cycles
    vt.push_back(mk(5, 0, 0, 16'h0000, 1, 16'h9999,
                    0, 1, 16'h2A05, 0, 3, 8'h2A, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h9999,
                      0, 1, 16'h2A05, 0, 3, 8'h2A, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h9999,
                    0, 0, 0, 0, 3, 8'h2A, 0, 0, 0));
    // Incoming call, third-party CALL, answer, peer hangup
    vt.push_back(mk(0, 0, 1, 16'h0701, 0, 16'h0000,
                    2, 0, 0, 0, 0, 8'h07, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 16'h0901, 0, 16'h0000,
                    2, 1, 16'h0903, 0, 0, 8'h07, 1, 0, 0));
    vt.push_back(mk(2, 0, 0, 16'h0000, 0, 16'h0000,
                    3, 1, 16'h0702, 0, 0, 8'h07, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h00AA,
                    3, 2, 16'h00AA, 1, 0, 8'h07, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 16'h0705, 0, 16'h0000,
                    0, 0, 0, 0, 3, 8'h07, 0, 0, 0));
    vt.push_back(mk(2, 0, 1, 16'h0705, 0, 16'h0000,
                    0, 0, 0, 0, 3, 8'h07, 0, 0, 0));
    // DIAL colliding with an incoming CALL, then reject
    vt.push_back(mk(1, 8'h2A, 1, 16'h5501, 0, 16'h0000,
                    2, 0, 0, 0, 0, 8'h55, 1, 0, 0));
    vt.push_back(mk(3, 0, 0, 16'h0000, 0, 16'h0000,
                    0, 1, 16'h5507, 0, 3, 8'h55, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000,
                    0, 0, 0, 0, 3, 8'h55, 0, 0, 0));

    foreach (vt[i]) begin
      drive(vt[i].ui, vt[i].ph, vt[i].ci, vt[i].pk, vt[i].bz, vt[i].ai);
      step();
      chk($sformatf("v%0d state", i), 32'(current_state), 32'(vt[i].st));
      chk($sformatf("v%0d cmd", i), 32'(cmd_out), 32'(vt[i].co));
      if (vt[i].co != 2'b00)
        chk($sformatf("v%0d data", i), 32'(data_out), 32'(vt[i].dout));
      chk($sformatf("v%0d flag", i), 32'(audio_in_flag), 32'(vt[i].fl));
      chk($sformatf("v%0d status", i), 32'(call_status), 32'(vt[i].cs));
      chk($sformatf("v%0d peer", i), 32'(peer_num), 32'(vt[i].pn));
      chk($sformatf("v%0d sbusy", i), 32'(session_busy), 32'(vt[i].sb));
      chk($sformatf("v%0d aov", i), 32'(audio_out_valid), 32'(vt[i].av));
      if (vt[i].av)
        chk($sformatf("v%0d aout", i), 32'(audio_out), 32'(vt[i].ao));
    end

    // CALLING timeout: NO_ANSWER 8 cycles after the CALL word is taken
    drive(5'd1, 8'h2A, 2'b00, 16'h0000, 1'b0, 16'h0000);
    step();
    chk("dial state", 32'(current_state), 1);
    idle();
    step();
    chk("dial accepted", 32'(cmd_out), 0);
    cnt = 0;
    while (current_state != 3'd5 && cnt < 40) begin
      step();
      cnt++;
    end
    chk("noans latency", 32'(cnt), 8);
    chk("noans cmd", 32'(cmd_out), 1);
    chk("noans data", 32'(data_out), 32'h2A05);
    step();
    chk("noans idle", 32'(current_state), 0);
    chk("noans status", 32'(call_status), 2);
    chk("noans sent", 32'(cmd_out), 0);

    // RINGING timeout
    drive(5'd0, 8'h00, 2'b01, 16'h0701, 1'b0, 16'h0000);
    step();
    chk("ring state", 32'(current_state), 2);
    idle();
    cnt = 0;
    while (current_state == 3'd2 && cnt < 40) begin
      step();
      cnt++;
    end
    chk("ring timeout", 32'(cnt), 9);
`ifdef VOICEMAIL_EN
    chk("vm state", 32'(current_state), 6);
    chk("vm cmd", 32'(cmd_out), 1);
    chk("vm data", 32'(data_out), 32'h0702);
    chk("vm active", 32'(vm_active), 1);
    cnt = 0;
    while (vm_active && cnt < 50) begin
      if (cnt == 0) drive(5'd0, 8'h00, 2'b10, 16'hABCD, 1'b0, 16'h7777);
      else drive(5'd0, 8'h00, 2'b00, 16'h0000, 1'b0, 16'h7777);
      step();
      cnt++;
      if (cnt == 1) begin
        chk("vm aov", 32'(audio_out_valid), 1);
        chk("vm aout", 32'(audio_out), 32'hABCD);
      end
      chk($sformatf("vm noaudio%0d", cnt), 32'(cmd_out == 2'b10), 0);
    end
    idle();
    chk("vm length", 32'(cnt), 6);
    chk("vm exit state", 32'(current_state), 0);
    chk("vm exit cmd", 32'(cmd_out), 1);
    chk("vm exit data", 32'(data_out), 32'h0705);
    step();
`else
    chk("ring to idle", 32'(current_state), 0);
    chk("ring to cmd", 32'(cmd_out), 0);
    chk("ring to vm", 32'(vm_active), 0);
`endif

    // Asynchronous reset while connected
    drive(5'd0, 8'h00, 2'b01, 16'h0701, 1'b0, 16'h0000);
    step();
    drive(5'd2, 8'h00, 2'b00, 16'h0000, 1'b0, 16'h5555);
    step();
    chk("rst pre state", 32'(current_state), 3);
    drive(5'd0, 8'h00, 2'b10, 16'h6666, 1'b0, 16'h5555);
    step();
    chk("rst pre cmd", 32'(cmd_out), 2);
    chk("rst pre aov", 32'(audio_out_valid), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post rst state", 32'(current_state), 0);
    chk("post rst cmd", 32'(cmd_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
